// File: rtl/uart_tx_shift.sv
// 8051-style serial transmitter: frames a byte written to SBUF onto txd, stepping one
// bit per OVS baud ticks (async modes) or per tick (sync shift mode), then raises TI.
module uart_tx_shift #(
  parameter int          OVS       = 16,
  parameter logic [7:0]  SBUF_ADDR = 8'h99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [7:0] AB,
  input  logic [7:0] din,
  input  logic [1:0] SM,
  input  logic       TB8,
  input  logic       TC,
  input  logic       ti_clr,
  output logic       TEN,
  output logic       txd,
  output logic       TI,
  output logic       busy,
  output logic [7:0] dout
);

  localparam int CW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(OVS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, NINTH, STOP, DONE} state_t;

  state_t         state, state_nxt;
  logic [7:0]     shreg;
  logic [7:0]     sbuf;
  logic [1:0]     mode;
  logic           b9;
  logic [CW-1:0]  tick_cnt;
  logic [2:0]     bit_cnt;
  logic           ti_q;
  logic           load;
  logic           adv;

  // Writes are only honoured between frames; a write during a frame is dropped entirely.
  assign load = !wr_n && (AB == SBUF_ADDR) && (state == IDLE);
  assign adv  = TC && ((mode == 2'b00) || (tick_cnt == TICK_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    txd       = 1'b1;
    case (state)
      IDLE:  if (load) state_nxt = (SM == 2'b00) ? DATA : START;
      START: begin
        txd = 1'b0;
        if (adv) state_nxt = DATA;
      end
      DATA: begin
        txd = shreg[0];
        if (adv && bit_cnt == 3'd7) begin
          if (mode[1])              state_nxt = NINTH;
          else if (mode == 2'b00)   state_nxt = DONE;
          else                      state_nxt = STOP;
        end
      end
      NINTH: begin
        txd = b9;
        if (adv) state_nxt = STOP;
      end
      STOP:  if (adv) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath; sbuf keeps the unshifted byte so readback stays stable mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= 8'h00;
      sbuf     <= 8'h00;
      mode     <= 2'b00;
      b9       <= 1'b0;
      tick_cnt <= '0;
      bit_cnt  <= 3'd0;
      ti_q     <= 1'b0;
    end else if (load) begin
      shreg    <= din;
      sbuf     <= din;
      mode     <= SM;
      b9       <= TB8;
      tick_cnt <= '0;
      bit_cnt  <= 3'd0;
      ti_q     <= 1'b0;
    end else begin
      if (state != IDLE && state != DONE && TC && mode != 2'b00)
        tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + 1'b1;
      if (state == DATA && adv) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
      // Completion beats a coincident clear so the CPU never misses a frame end.
      if (state == DONE)  ti_q <= 1'b1;
      else if (ti_clr)    ti_q <= 1'b0;
    end
  end

  assign TEN  = (state != IDLE);
  assign busy = TEN;
  assign TI   = ti_q;
  assign dout = (!rd_n && AB == SBUF_ADDR) ? sbuf : 8'h00;

endmodule

// File: tb/tb_uart_tx_shift.sv
// Scoreboard bench for uart_tx_shift: expected txd bits are queued at each write and
// popped when the bit is sampled mid-period.
module tb_uart_tx_shift;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_n = 1'b1;
  logic       rd_n = 1'b1;
  logic [7:0] AB = 8'h00;
  logic [7:0] din = 8'h00;
  logic [1:0] SM = 2'b00;
  logic       TB8 = 1'b0;
  logic       TC = 1'b0;
  logic       ti_clr = 1'b0;
  logic       TEN, txd, TI, busy;
  logic [7:0] dout;

  int checks = 0;
  int passes = 0;
  logic exp_q[$];

  uart_tx_shift #(.OVS(OVS), .SBUF_ADDR(8'h99)) dut (
    .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .rd_n(rd_n), .AB(AB), .din(din),
    .SM(SM), .TB8(TB8), .TC(TC), .ti_clr(ti_clr),
    .TEN(TEN), .txd(txd), .TI(TI), .busy(busy), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic push_frame(input logic [7:0] data, input logic [1:0] sm, input logic tb8);
    if (sm != 2'b00) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
    if (sm[1]) exp_q.push_back(tb8);
    if (sm != 2'b00) exp_q.push_back(1'b1);
  endtask

  task automatic bus_write(input logic [7:0] data);
    AB = 8'h99; din = data; wr_n = 1'b0;
    @(posedge clk); #1;
    wr_n = 1'b1; din = 8'h00;
  endtask

  // Sends one frame with TC every 'period' clocks; optionally writes 8'hFF mid-frame
  // (before pulse wr_at) and/or pulses ti_clr in the DONE cycle.
  task automatic run_frame(input logic [7:0] data, input logic [1:0] sm, input logic tb8,
                           input int period, input int wr_at, input bit clr_in_done);
    int total;
    logic exp_bit;
    SM = sm; TB8 = tb8;
    push_frame(data, sm, tb8);
    bus_write(data);
    checks++;
    if (TI !== 1'b0) $display("[TB] FAIL load_clears_ti: TI=%b expected 0", TI);
    else passes++;
    SM = ~sm; TB8 = ~tb8;
    total = (sm == 2'b00) ? 8 : ((sm == 2'b01) ? 10 * OVS : 11 * OVS);
    for (int n = 0; n < total; n++) begin
      for (int g = 0; g < period - 1; g++) begin
        if (n == wr_at && g == 0) begin
          AB = 8'h99; din = 8'hFF; wr_n = 1'b0;
        end
        @(posedge clk); #1;
        if (n == wr_at && g == 0) begin
          wr_n = 1'b1; din = 8'h00; rd_n = 1'b0; #1;
          checks++;
          if (dout !== data) $display("[TB] FAIL dout_busy_write: dout=%h expected %h", dout, data);
          else passes++;
          checks++;
          if (TI !== 1'b0) $display("[TB] FAIL ti_busy_write: TI=%b expected 0", TI);
          else passes++;
          rd_n = 1'b1;
        end
      end
      TC = 1'b1;
      @(negedge clk);
      if (sm == 2'b00 || (n % OVS) == OVS / 2) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL txd_bit: txd=%b but no bit expected", txd);
        else begin
          exp_bit = exp_q.pop_front();
          if (txd !== exp_bit) $display("[TB] FAIL txd_bit pulse %0d: txd=%b expected %b", n, txd, exp_bit);
          else passes++;
        end
      end
      if (n == total - 1) begin
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL busy_before_last_tc: busy=%b expected 1", busy);
        else passes++;
      end
      @(posedge clk); #1;
      TC = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || TI !== 1'b0)
      $display("[TB] FAIL done_cycle: busy=%b TI=%b expected busy=1 TI=0", busy, TI);
    else passes++;
    if (clr_in_done) ti_clr = 1'b1;
    @(posedge clk); #1;
    ti_clr = 1'b0;
    checks++;
    if (TI !== 1'b1 || TEN !== 1'b0 || busy !== 1'b0 || txd !== 1'b1)
      $display("[TB] FAIL frame_end: TI=%b TEN=%b busy=%b txd=%b expected 1 0 0 1", TI, TEN, busy, txd);
    else passes++;
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL bits_left: %0d expected 0", exp_q.size());
    else passes++;
    exp_q.delete();
  endtask

  task automatic test_reset;
    #12;
    rd_n = 1'b0; AB = 8'h99; #1;
    checks++;
    if (txd !== 1'b1 || TEN !== 1'b0 || TI !== 1'b0 || busy !== 1'b0 || dout !== 8'h00)
      $display("[TB] FAIL reset_state: txd=%b TEN=%b TI=%b busy=%b dout=%h expected 1 0 0 0 00",
               txd, TEN, TI, busy, dout);
    else passes++;
    rd_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_async8;
    run_frame(8'hA5, 2'b01, 1'b0, 6, -1, 1'b0);
  endtask

  task automatic test_async9;
    run_frame(8'h00, 2'b11, 1'b1, 3, -1, 1'b0);
  endtask

  task automatic test_sync;
    run_frame(8'h3C, 2'b00, 1'b0, 1, -1, 1'b0);
  endtask

  task automatic test_write_busy;
    run_frame(8'h55, 2'b01, 1'b0, 6, 40, 1'b0);
    rd_n = 1'b0; AB = 8'h98; #1;
    checks++;
    if (dout !== 8'h00) $display("[TB] FAIL dout_unselected: dout=%h expected 00", dout);
    else passes++;
    rd_n = 1'b1; AB = 8'h99; #1;
    checks++;
    if (dout !== 8'h00) $display("[TB] FAIL dout_no_read: dout=%h expected 00", dout);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_ti_clear;
    run_frame(8'h96, 2'b01, 1'b0, 1, -1, 1'b1);
    ti_clr = 1'b1;
    @(posedge clk); #1;
    ti_clr = 1'b0;
    checks++;
    if (TI !== 1'b0) $display("[TB] FAIL ti_clr: TI=%b expected 0", TI);
    else passes++;
    run_frame(8'h3F, 2'b00, 1'b0, 2, -1, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_frame(8'hC3, 2'b10, 1'b0, 1, -1, 1'b0);
    run_frame(8'h5A, 2'b01, 1'b0, 2, -1, 1'b0);
  endtask

  task automatic test_reset_mid_frame;
    SM = 2'b01; TB8 = 1'b0;
    bus_write(8'h00);
    for (int n = 0; n < OVS + 3 * OVS + OVS / 2; n++) begin
      TC = 1'b1;
      @(posedge clk); #1;
      TC = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (txd !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL mid_frame: txd=%b busy=%b expected 0 1", txd, busy);
    else passes++;
    rst_n = 1'b0; #1;
    checks++;
    if (txd !== 1'b1 || TEN !== 1'b0 || TI !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL async_abort: txd=%b TEN=%b TI=%b busy=%b expected 1 0 0 0", txd, TEN, TI, busy);
    else passes++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(8'h81, 2'b01, 1'b0, 1, -1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_async8;
    test_async9;
    test_sync;
    test_write_busy;
    test_ti_clear;
    test_back_to_back;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
